// File: rtl/uart_rx_if.sv
// Receive-side bus of the 8N1 UART receiver: recovered byte plus status pulses.
// master is the receiver that drives the bus; slave is the byte consumer.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_busy,
        output frame_err
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input rx_busy,
        input frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by an oversampled baud tick; 3-sample majority vote per bit,
// glitch-start rejection, framing-error pulse, one-cycle valid pulse per good byte.
module uart_rx #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        baud_tick_os,
    input  logic        rx_line,
    uart_rx_if.master   bus
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned M  = OVERSAMPLE / 2;

    localparam logic [CW-1:0] SAMPLE_A = CW'(M - 1);
    localparam logic [CW-1:0] SAMPLE_B = CW'(M);
    localparam logic [CW-1:0] SAMPLE_C = CW'(M + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic          rx_meta;
    logic          rx_s;
    logic [1:0]    state;
    logic [CW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          samp_a;
    logic          samp_b;
    logic          majority;
    logic          commit;
    logic          wrap;

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_busy;
    logic          frame_err;

    // Synchronizer resets to the idle line level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_line;
            rx_s    <= rx_meta;
        end
    end

    // Third sample is taken live on the commit tick, so the vote uses rx_s directly.
    always_comb begin
        majority = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
        commit   = baud_tick_os && (tick_cnt == SAMPLE_C);
        wrap     = baud_tick_os && (tick_cnt == LAST_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            if (baud_tick_os) begin
                if (state != ST_IDLE) begin
                    tick_cnt <= tick_cnt + 1'b1;
                    if (tick_cnt == SAMPLE_A)
                        samp_a <= rx_s;
                    if (tick_cnt == SAMPLE_B)
                        samp_b <= rx_s;
                end

                case (state)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state    <= ST_START;
                            tick_cnt <= '0;
                            rx_busy  <= 1'b1;
                        end
                    end

                    ST_START: begin
                        if (commit && majority) begin
                            state    <= ST_IDLE;
                            tick_cnt <= '0;
                            rx_busy  <= 1'b0;
                        end else if (wrap) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end

                    ST_DATA: begin
                        if (commit)
                            shift_reg <= {majority, shift_reg[7:1]};
                        if (wrap) begin
                            if (bit_cnt == 3'd7)
                                state <= ST_STOP;
                            else
                                bit_cnt <= bit_cnt + 3'd1;
                        end
                    end

                    // Return to IDLE at mid stop bit so a following start edge is caught early.
                    ST_STOP: begin
                        if (commit) begin
                            if (majority) begin
                                rx_data  <= shift_reg;
                                rx_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state    <= ST_IDLE;
                            tick_cnt <= '0;
                            rx_busy  <= 1'b0;
                        end
                    end

                    default: begin
                        state    <= ST_IDLE;
                        tick_cnt <= '0;
                        rx_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rx_data   = rx_data;
    assign bus.rx_valid  = rx_valid;
    assign bus.rx_busy   = rx_busy;
    assign bus.frame_err = frame_err;

endmodule
